// File: rtl/div_seq_pkg.sv
// Shared widths, handshake levels, FSM encoding and sign helpers for the
// sequential divider.
package div_seq_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  // Magnitude of a word, only treating bit 31 as a sign for signed divides.
  function automatic logic [RegBus-1:0] magnitude(input logic [RegBus-1:0] v,
                                                  input logic isSigned);
    return (isSigned && v[RegBus-1]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [RegBus-1:0] negateIf(input logic [RegBus-1:0] v,
                                                 input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift the work register left, trial
// subtract the divisor from the remainder half and keep or restore.
module div_step
  import div_seq_pkg::*;
(
  input  logic [DoubleRegBus:0] i_work,
  input  logic [RegBus-1:0]     i_divisor,
  output logic [DoubleRegBus:0] o_work
);

  // Subtracting over 34 bits keeps the sign bit clear of the shifted remainder.
  logic [RegBus+1:0] w_trial;

  assign w_trial = i_work[DoubleRegBus:RegBus-1] - {2'b00, i_divisor};

  assign o_work = w_trial[RegBus+1]
                  ? {i_work[DoubleRegBus-1:0], 1'b0}
                  : {w_trial[RegBus:0], i_work[RegBus-2:0], 1'b1};

endmodule

// File: rtl/div_seq.sv
// Multicycle radix-2 restoring divider for DIV/DIVU with start/ready handshake
// and flush annul. Define DIV_ZERO_DETECT_EN to short-cut zero divisors.
module div_seq
  import div_seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_t             r_state;
  logic [4:0]             r_cnt;
  logic [DoubleRegBus:0]  r_work;
  logic [RegBus-1:0]      r_divisor;
  logic                   r_quoNeg;
  logic                   r_remNeg;
  logic [DoubleRegBus:0]  w_nextWork;

  div_step u_step (
    .i_work    (r_work),
    .i_divisor (r_divisor),
    .o_work    (w_nextWork)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= DivFree;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_quoNeg  <= 1'b0;
      r_remNeg  <= 1'b0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else if (annul_i) begin
      r_state  <= DivFree;
      r_cnt    <= '0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          if (start_i == DivStart) begin
            r_work    <= {33'b0, magnitude(opdata1_i, signed_div_i)};
            r_divisor <= magnitude(opdata2_i, signed_div_i);
            r_quoNeg  <= signed_div_i & (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
            r_remNeg  <= signed_div_i & opdata1_i[RegBus-1];
            r_cnt     <= '0;
`ifdef DIV_ZERO_DETECT_EN
            r_state   <= (opdata2_i == ZeroWord) ? DivByZero : DivOn;
`else
            r_state   <= DivOn;
`endif
          end
        end
        DivByZero: begin
          result_o <= '0;
          ready_o  <= DivResultReady;
          r_state  <= DivEnd;
        end
        DivOn: begin
          r_work <= w_nextWork;
          r_cnt  <= r_cnt + 5'd1;
          // Last iteration: results come straight from this step's output.
          if (r_cnt == 5'd31) begin
            result_o <= {negateIf(w_nextWork[DoubleRegBus-1:RegBus], r_remNeg),
                         negateIf(w_nextWork[RegBus-1:0], r_quoNeg)};
            ready_o  <= DivResultReady;
            r_state  <= DivEnd;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            result_o <= '0;
            ready_o  <= DivResultNotReady;
            r_state  <= DivFree;
          end
        end
        default: r_state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, randomized divides
// against an arithmetic reference model, and annul/reset/hold sequences.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[6];

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division; C-style truncation matches DIV/DIVU.
  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Runs one division with start held until ready, optionally holds start in
  // END, then drops start and checks the outputs clear. Operands are
  // scrambled right after acceptance.
  task automatic applyStimulus(input string name, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp, input int lat,
                               input int hold);
    int edges;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk); #1;
    edges        = 1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sgn;
    while (!ready_o && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({name, " latency"}, 64'(edges), 64'(lat));
    checkOutput({name, " result"}, result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({name, " hold ready"}, 64'(ready_o), 64'd1);
      checkOutput({name, " hold result"}, result_o, exp);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    checkOutput({name, " clear ready"}, 64'(ready_o), 64'd0);
    checkOutput({name, " clear result"}, result_o, 64'd0);
  endtask

  initial begin
    int highs;
    int edges;
    logic [31:0] ra, rb;
    logic        rs;

    vecs[0] = '{1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0};
    vecs[2] = '{1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33, 0};
`ifdef DIV_ZERO_DETECT_EN
    vecs[3] = '{1'b0, 32'd5, 32'd0, 64'd0, 2, 0};
`else
    vecs[3] = '{1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 33, 0};
`endif
    vecs[4] = '{1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 5};
    vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33, 0};

    rst          = 1'b0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    #12;
    checkOutput("reset ready", 64'(ready_o), 64'd0);
    checkOutput("reset result", result_o, 64'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].exp, vecs[i].lat, vecs[i].hold);

    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        rb = $urandom_range(1, 100);
        if (rs && $urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
      end
      if (rb == 32'd0) rb = 32'd1;
      applyStimulus($sformatf("rand%0d", i), rs, ra, rb, refDiv(rs, ra, rb), 33, 0);
    end

    // Annul on the 10th ON cycle: no result may ever appear.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    checkOutput("annul ready", 64'(ready_o), 64'd0);
    checkOutput("annul result", result_o, 64'd0);
    highs = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) highs++;
    end
    checkOutput("annul ready never rises", 64'(highs), 64'd0);
    applyStimulus("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

    // Async reset while a result is held in END must clear it mid-cycle.
    signed_div_i = 1'b0;
    opdata1_i    = 32'hFFFFFFFF;
    opdata2_i    = 32'd1;
    start_i      = 1'b1;
    edges        = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!ready_o && edges < 100);
    checkOutput("pre-reset result", result_o, {32'd0, 32'hFFFFFFFF});
    #2 rst = 1'b0;
    #1;
    checkOutput("reset in END ready", 64'(ready_o), 64'd0);
    checkOutput("reset in END result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    // Async reset at the 20th ON cycle, then a clean signed overflow case.
    opdata1_i = 32'd12345;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    @(posedge clk); #1;
    repeat (19) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    checkOutput("reset in ON ready", 64'(ready_o), 64'd0);
    checkOutput("reset in ON result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    applyStimulus("after reset min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF,
                  {32'd0, 32'h80000000}, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multicycle radix-2 restoring divider sequencer for the EX stage. It accepts DIV/DIVU operands from EX through a start/ready handshake and runs the division over 32 iterations. It returns {remainder, quotient} for the HI/LO writeback. EX holds its stall request for as long as the divider is busy; the pipeline controller can annul an in-flight division on flush.

## Interface
Parameters:
- none; all widths come from the shared package.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-low reset.
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  input  32  dividend; sampled only on start acceptance.
- opdata2_i  input  32  divisor; sampled only on start acceptance.
- start_i  input  1  DivStart/DivStop request from EX.
- annul_i  input  1  flush; aborts the current division.
- result_o  output  64  [63:32] remainder (HI), [31:0] quotient (LO).
- ready_o  output  1  DivResultReady while in END.

## Operation
- Four states: FREE, BYZERO, ON, END.
- FREE:
  - If start_i=1 and annul_i=0, capture the operands.
  - Take the magnitude of each negative operand when signed_div_i=1.
  - Record the quotient sign (s1^s2) and the remainder sign (s1).
  - Go to ON with cnt=0, or to BYZERO if the divisor is 0 (requires DIV_ZERO_DETECT_EN).
- ON, per cycle:
  - Work register is 65 bits, {rem[32:0], quo[31:0]}.
  - Shift left by 1, trial subtract = rem[32:0] − {1'b0, divisor}.
  - If the trial subtraction is non-negative, keep the difference and set quotient bit 1; otherwise restore and set it to 0.
  - Increment cnt.
  - After the step with cnt=31, apply the sign fix (two's-complement negate where the recorded sign is 1), load result_o, set ready_o=1 and go to END.
- BYZERO: load result_o=0, set ready_o=1, go to END.
- END:
  - start_i=1: hold state, ready_o and result_o.
  - start_i=0: go to FREE, clear ready_o and result_o to 0.
- annul_i=1 in any state forces FREE at the next edge, with ready_o=0 and result_o=0. annul_i has priority over start_i.
- Operand changes after acceptance are ignored.
- 0x80000000 / 0xFFFFFFFF signed gives LO=0x80000000, HI=0. No trap.

## Timing
- Reset: state=FREE, cnt=0, ready_o=0, result_o=0, all asynchronous.
- Let start be accepted at edge E:
  - Normal path: iterations run on edges E+1..E+32. ready_o and result_o are valid after edge E+32, a latency of 33 cycles.
  - BYZERO path: valid after edge E+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- EX drops start_i in the cycle it sees ready_o. ready_o therefore stays high for exactly one cycle in normal use.
- A new start is accepted no earlier than the cycle after the return to FREE.
- Reset asserted mid-ON clears everything immediately. No partial result leaks.

## Configuration
- DIV_ZERO_DETECT_EN defined:
  - A zero divisor goes FREE→BYZERO→END.
  - result_o=0, 2-cycle latency.
- Not defined:
  - No zero check; the full 33-cycle iteration runs.
  - Result is the natural algorithm output: quotient 0xFFFFFFFF and remainder |dividend| before the sign fix. Example: DIVU 5/0 gives HI=5, LO=0xFFFFFFFF.

## Structure
- Shared package/defines:
  - State encodings DivFree, DivByZero, DivOn, DivEnd.
  - DivStart/DivStop, DivResultReady/DivResultNotReady.
  - RegBus and DoubleRegBus widths, ZeroWord.
- One combinational sub-module, div_step: 33-bit trial subtract and select, returning the next 65-bit work register.
- FSM, counter and sign fix stay in div_seq.

## Test plan
- DIVU 100/7, start held until ready → ready_o after 33 cycles, HI=2, LO=14; drop start → ready_o=0 and result_o=0 next edge.
- DIV −7/2 (0xFFFFFFF9 / 2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 7/−2 → LO=0xFFFFFFFD, HI=1.
- DIVU 5/0:
  - With DIV_ZERO_DETECT_EN → ready after 2 cycles, result 0.
  - Without it → ready after 33 cycles, HI=5, LO=0xFFFFFFFF.
- annul_i pulsed at the 10th ON cycle → ready_o never rises and state returns to FREE. A following DIVU 9/3 gives HI=0, LO=3 in 33 cycles.
- rst low at the 20th ON cycle → all outputs 0 immediately. After release, DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- start_i held high 5 cycles in END → ready_o and result_o stable. Operand changes during ON do not alter the result.
